// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: owns the register file write port and shares it between NSRC
// writeback sources with a round-robin arbiter. After reset, it can first zero
// every register.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   src_valid  per-source write request
//   src_ready  per-source grant (combinational, never depends on itself)
//   src_addr   packed destination addresses, source i at [i*AW +: AW]
//   src_data   packed write data, source i at [i*DW +: DW]
//   hold       freezes granting for this cycle
//   wa/wda     registered register-file write address / data
//   reg_wr     registered register-file write enable
//   init_done  set once the clear sequence has finished (or was skipped)
module reg_wb_arbiter #(
    parameter int unsigned NSRC           = 3,
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          R0_ZERO        = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic               hold,
    output logic [AW-1:0]      wa,
    output logic [DW-1:0]      wda,
    output logic               reg_wr,
    output logic               init_done
);

    localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [PW-1:0] ptr_q;

    logic          xfer;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Round-robin search starting at ptr_q; only src_valid, ptr_q, hold and
    // state feed the grant, so there is no ready->ready path.
    always_comb begin
        int unsigned idx;
        src_ready = '0;
        win       = '0;
        xfer      = 1'b0;
        idx       = 0;
        if (state_q == StRun && !hold) begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                idx = (32'(ptr_q) + k) % NSRC;
                if (!xfer && src_valid[idx]) begin
                    xfer = 1'b1;
                    win  = PW'(idx);
                end
            end
        end
        if (xfer) begin
            src_ready[win] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = src_addr[32'(win)*AW +: AW];
        sel_data = src_data[32'(win)*DW +: DW];
        ptr_nxt  = (32'(win) == NSRC - 1) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StClear;
            cnt_q     <= '0;
            ptr_q     <= '0;
            wa        <= '0;
            wda       <= '0;
            reg_wr    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    if (!CLEAR_ON_RESET) begin
                        state_q   <= StRun;
                        init_done <= 1'b1;
                        reg_wr    <= 1'b0;
                    end else begin
                        wa     <= cnt_q;
                        wda    <= '0;
                        reg_wr <= 1'b1;
                        cnt_q  <= cnt_q + AW'(1);
                        if (&cnt_q) begin
                            state_q   <= StRun;
                            init_done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        wa     <= sel_addr;
                        wda    <= sel_data;
                        // Writes to r0 still consume a grant but never reach the file.
                        reg_wr <= !(R0_ZERO && sel_addr == '0);
                        ptr_q  <= ptr_nxt;
                    end else begin
                        reg_wr <= 1'b0;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

endmodule
